data_write_buffer: RTL and testbench



---
 rtl/data_write_buffer.sv | 139 +++++++++++++
 tb/tb_data_write_buffer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/data_write_buffer.sv
// Posted write buffer between the core MEM stage and a slower data memory: stores retire into a
// FIFO, drain over a valid/ready channel, and loads forward from the youngest matching entry.
// Optional store coalescing into the youngest entry is enabled by defining WBUF_COALESCE_EN.
module data_write_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        data_addr,
    input  logic [DATA_W-1:0]        data_write,
    input  logic                     mem_write_en,
    input  logic                     mem_read_en,
    output logic [DATA_W-1:0]        data_read,
    output logic [ADDR_W-1:0]        bus_raddr,
    input  logic [DATA_W-1:0]        bus_rdata,
    output logic [ADDR_W-1:0]        bus_waddr,
    output logic [DATA_W-1:0]        bus_wdata,
    output logic                     bus_wvalid,
    input  logic                     bus_wready,
    output logic [$clog2(DEPTH):0]   wbuf_count,
    output logic                     wbuf_full,
    output logic                     wbuf_empty,
    output logic                     overflow_err
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              overflow_q, overflow_d;

    logic              full, empty, push, pop, coalesce;
    logic [ADDR_W-1:0] store_addr;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [PtrW-1:0]   fwd_idx;

    assign full       = (count_q == CntW'(DEPTH));
    assign empty      = (count_q == '0);
    assign pop        = !empty && bus_wready;
    assign store_addr = {data_addr[ADDR_W-1:2], 2'b00};

`ifdef WBUF_COALESCE_EN
    logic [PtrW-1:0] tail_idx;
    assign tail_idx = wr_ptr_q - PtrW'(1);
    // With at least two entries the youngest is never the head, so merging keeps the head stable.
    assign coalesce = mem_write_en && (count_q >= CntW'(2)) &&
                      (addr_q[tail_idx][ADDR_W-1:2] == data_addr[ADDR_W-1:2]);
`else
    assign coalesce = 1'b0;
`endif

    assign push = mem_write_en && !coalesce && (!full || pop);

    always_comb begin
        addr_d     = addr_q;
        data_d     = data_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push) begin
            addr_d[wr_ptr_q] = store_addr;
            data_d[wr_ptr_q] = data_write;
            wr_ptr_d         = wr_ptr_q + PtrW'(1);
        end
`ifdef WBUF_COALESCE_EN
        if (coalesce) begin
            data_d[tail_idx] = data_write;
        end
`endif
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        if (mem_write_en && !coalesce && full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '{default: '0};
            data_q     <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            data_q     <= data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Walk oldest to youngest so the last hit wins; pre-update state gives load-before-store order.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = rd_ptr_q + PtrW'(k);
            if ((CntW'(k) < count_q) &&
                (addr_q[fwd_idx][ADDR_W-1:2] == data_addr[ADDR_W-1:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fwd_idx];
            end
        end
    end

    assign data_read    = mem_read_en ? (fwd_hit ? fwd_data : bus_rdata) : '0;
    assign bus_raddr    = data_addr;
    assign bus_waddr    = addr_q[rd_ptr_q];
    assign bus_wdata    = data_q[rd_ptr_q];
    assign bus_wvalid   = !empty;
    assign wbuf_count   = count_q;
    assign wbuf_full    = full;
    assign wbuf_empty   = empty;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_data_write_buffer.sv
// Scoreboard bench for data_write_buffer: a queue-based reference model predicts status, load data
// and drain order; a negedge monitor compares. Honours WBUF_COALESCE_EN like the design.
module tb_data_write_buffer;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_addr, data_write, data_read, bus_raddr, bus_rdata, bus_waddr, bus_wdata;
    logic        mem_write_en, mem_read_en, bus_wvalid, bus_wready;
    logic [2:0]  wbuf_count;
    logic        wbuf_full, wbuf_empty, overflow_err;

    int vectors = 0;
    int fails   = 0;

    typedef struct {
        bit          rst;
        bit          re;
        logic [31:0] rd;
        int          cnt;
        bit          ovf;
    } exp_t;

    exp_t        sq[$];
    logic [63:0] dq[$];
    logic [31:0] m_addr[$];
    logic [31:0] m_data[$];
    bit          m_ovf;

    always #5 clk = ~clk;

    data_write_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_addr    (data_addr),
        .data_write   (data_write),
        .mem_write_en (mem_write_en),
        .mem_read_en  (mem_read_en),
        .data_read    (data_read),
        .bus_raddr    (bus_raddr),
        .bus_rdata    (bus_rdata),
        .bus_waddr    (bus_waddr),
        .bus_wdata    (bus_wdata),
        .bus_wvalid   (bus_wvalid),
        .bus_wready   (bus_wready),
        .wbuf_count   (wbuf_count),
        .wbuf_full    (wbuf_full),
        .wbuf_empty   (wbuf_empty),
        .overflow_err (overflow_err)
    );

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, predict outputs from the model, then advance the model.
    task automatic step(input bit rst, input bit we, input bit re, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdata, input bit wr);
        exp_t        e;
        logic [31:0] wa;
        int          n;
        bit          do_pop;
        bit          merge;
        reset = rst; mem_write_en = we; mem_read_en = re; data_addr = a;
        data_write = wd; bus_rdata = rdata; bus_wready = wr;
        wa = {a[31:2], 2'b00};
        n  = m_addr.size();

        e.rst = rst; e.re = re; e.cnt = n; e.ovf = m_ovf; e.rd = rdata;
        for (int i = 0; i < n; i++) if (m_addr[i] == wa) e.rd = m_data[i];
        sq.push_back(e);

        if (rst) begin
            m_addr.delete(); m_data.delete(); m_ovf = 1'b0;
        end else begin
            do_pop = (n > 0) && wr;
            merge  = 1'b0;
`ifdef WBUF_COALESCE_EN
            merge = we && (n >= 2) && (m_addr[n-1] == wa);
`endif
            if (merge) begin
                m_data[n-1] = wd;
                dq[dq.size()-1] = {wa, wd};
            end
            if (do_pop) begin
                void'(m_addr.pop_front()); void'(m_data.pop_front());
            end
            if (we && !merge) begin
                if (n < DEPTH || do_pop) begin
                    m_addr.push_back(wa); m_data.push_back(wd); dq.push_back({wa, wd});
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sq.size() > 0) begin
            e = sq.pop_front();
            cmp("count", 64'(wbuf_count), 64'(e.cnt));
            cmp("full", 64'(wbuf_full), 64'(e.cnt == DEPTH));
            cmp("empty", 64'(wbuf_empty), 64'(e.cnt == 0));
            cmp("wvalid", 64'(bus_wvalid), 64'(e.cnt != 0));
            cmp("overflow", 64'(overflow_err), 64'(e.ovf));
            cmp("raddr", 64'(bus_raddr), 64'(data_addr));
            if (e.re) cmp("data_read", 64'(data_read), 64'(e.rd));
            if (e.rst) begin
                dq.delete();
            end else if (bus_wvalid) begin
                if (dq.size() == 0) begin
                    cmp("drain_unexpected", 64'(bus_wvalid), 64'(0));
                end else begin
                    cmp("drain_head", {bus_waddr, bus_wdata}, dq[0]);
                    if (bus_wready) void'(dq.pop_front());
                end
            end
        end
    end

    initial begin
        reset = 1'b1; mem_write_en = 1'b0; mem_read_en = 1'b0; data_addr = '0;
        data_write = '0; bus_rdata = '0; bus_wready = 1'b0; m_ovf = 1'b0;
        @(posedge clk);
        #1;

        // Single store presented next cycle and held while not ready.
        step(0, 1, 0, 32'h100, 32'hAAAA0001, 0, 0);
        cmp("tp1_waddr", 64'(bus_waddr), 64'h100);
        cmp("tp1_wdata", 64'(bus_wdata), 64'hAAAA0001);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0);

        // Fill, overflow, drain in order.
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 32'(i * 4), 32'(i + 16), 0, 0);
        step(0, 1, 0, 32'h10, 32'h99, 0, 0);
        cmp("tp2_full", 64'(wbuf_full), 64'd1);
        cmp("tp2_count", 64'(wbuf_count), 64'd4);
        cmp("tp2_ovf", 64'(overflow_err), 64'd1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 1);
        cmp("tp2_empty", 64'(wbuf_empty), 64'd1);

        // Forwarding from the youngest match; miss falls through to memory.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 32'h20, 32'h11, 0, 0);
        step(0, 1, 0, 32'h20, 32'h22, 0, 0);
        step(0, 0, 1, 32'h20, 0, 32'hDEAD, 0);
        step(0, 0, 1, 32'h24, 0, 32'hDEAD, 0);

        // Store into a full buffer while it pops.
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 32'(i * 4), 32'(i), 0, 0);
        step(0, 1, 0, 32'h40, 32'h5, 0, 1);
        cmp("tp4_count", 64'(wbuf_count), 64'd4);
        cmp("tp4_ovf", 64'(overflow_err), 64'd0);
        step(0, 0, 1, 32'h40, 0, 32'hBEEF, 0);

        // Repeated store to the youngest address.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 32'h0, 32'h1, 0, 0);
        step(0, 1, 0, 32'h4, 32'h2, 0, 0);
        step(0, 1, 0, 32'h4, 32'h3, 0, 0);
`ifdef WBUF_COALESCE_EN
        cmp("tp5_count", 64'(wbuf_count), 64'd2);
`else
        cmp("tp5_count", 64'(wbuf_count), 64'd3);
`endif
        step(0, 0, 1, 32'h4, 0, 32'h77, 0);

        // Reset mid-drain discards everything.
        step(0, 1, 0, 32'h8, 32'h8, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1);
        cmp("tp6_count", 64'(wbuf_count), 64'd0);
        cmp("tp6_wvalid", 64'(bus_wvalid), 64'd0);
        step(0, 0, 1, 32'h4, 0, 32'h1234, 0);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 6),
                 $urandom_range(0, 1) == 1, 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3)),
                 $urandom, $urandom, ($urandom_range(0, 9) < 4));
        end
        step(0, 0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
